// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between fetch and the memory stage. Data wins unless fetch is starved.
// Latency : the grant is combinational in IDLE. rvalid is routed combinationally from mem_rvalid.
// Backpress: mem_ready=0 holds the selected request without a grant. Only one transaction is in flight.
// Optional : define MEM_ARB_PERF_EN to add the perf_conflict_cnt and perf_starve_cnt counters.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_conflict_cnt,
    output logic [31:0]         perf_starve_cnt
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic       owner_store, owner_store_nxt;
    logic [3:0] starve_cnt;
    logic       starved;

    // Fetch has waited through STARVE_LIMIT data grants and must win the next arbitration.
    assign starved = (starve_cnt == LIMIT);

    // Arbitration, port muxing and response routing. Everything is held at 0 while reset is low.
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        owner_store_nxt = owner_store;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_be          = '0;
        mem_addr        = '0;
        mem_wdata       = '0;
        if_gnt          = 1'b0;
        d_gnt           = 1'b0;
        if_rvalid       = 1'b0;
        if_rdata        = '0;
        d_rvalid        = 1'b0;
        d_rdata         = '0;
        if (reset) begin
            case (state)
                S_IDLE: begin
                    if (if_req && (starved || !d_req)) begin
                        // A fetch is a plain word read. Byte enables stay 0 because mem_we=0.
                        mem_req  = 1'b1;
                        mem_addr = if_addr;
                        if (mem_ready) begin
                            if_gnt          = 1'b1;
                            owner_nxt       = OWN_IF;
                            owner_store_nxt = 1'b0;
                            state_nxt       = S_WAIT;
                        end
                    end else if (d_req) begin
                        mem_req   = 1'b1;
                        mem_we    = d_we;
                        mem_be    = d_be;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        if (mem_ready) begin
                            d_gnt           = 1'b1;
                            owner_nxt       = OWN_D;
                            owner_store_nxt = d_we;
                            state_nxt       = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state_nxt = S_IDLE;
                        owner_nxt = OWN_NONE;
                        case (owner)
                            OWN_IF: begin
                                if_rvalid = 1'b1;
                                if_rdata  = mem_rdata;
                            end
                            OWN_D: begin
                                d_rvalid = 1'b1;
                                d_rdata  = owner_store ? '0 : mem_rdata;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_rvalid;
    assign stall_mem = d_req & ~d_rvalid;

    // State and owner registers. A reset drops any outstanding response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            owner       <= OWN_NONE;
            owner_store <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            owner_store <= owner_store_nxt;
        end
    end

    // Count the data grants made while fetch waits. Clear when fetch is served or goes away.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Count IDLE cycles with both requesters active, and fetch grants forced by starvation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_conflict_cnt <= '0;
            perf_starve_cnt   <= '0;
        end else begin
            if ((state == S_IDLE) && if_req && d_req)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            if (if_gnt && d_req && starved)
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : checks mem_port_arbiter cycle by cycle against a transaction-level reference model.
// Latency : the memory model answers 1..4 cycles after a grant, with configurable phases.
// Backpress: mem_ready is randomized per phase. Requesters hold a request until its rvalid.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt, perf_starve_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflict_cnt(perf_conflict_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time and a count of data wins while fetch waits.
    bit          m_busy = 0, m_own_d = 0, m_own_store = 0;
    int          m_starve = 0;
    int          m_cd = -1;            // cycles until the memory answers; -1 means nothing is scheduled
    logic [31:0] m_pc = '0, m_ps = '0;

    // Requester and stimulus state.
    bit          f_pend = 0, d_pend = 0, d_we_r = 0;
    logic [31:0] f_addr = '0, d_addr_r = '0, d_wdata_r = '0;
    logic [3:0]  d_be_r = '0;
    int          p_if = 0, p_d = 0, p_ready = 100, p_spur = 0, lat_lo = 1, lat_hi = 1;
    bit          plan_vals = 0, in_reset = 1;
    bit          obs_d_gnt = 0;

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic cycle();
        logic e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_mreq, e_mwe, e_forced;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr, e_mwdata, e_if_rd, e_d_rd;
        @(negedge clk);
        if (!in_reset && !f_pend && roll(p_if)) begin
            f_pend = 1;
            f_addr = plan_vals ? 32'h100 : ($urandom & 32'hFFFF_FFFC);
        end
        if (!in_reset && !d_pend && roll(p_d)) begin
            d_pend    = 1;
            d_we_r    = plan_vals ? 1'b1 : 1'($urandom_range(1));
            d_be_r    = plan_vals ? 4'b0011 : 4'($urandom);
            d_addr_r  = plan_vals ? 32'h40 : $urandom;
            d_wdata_r = plan_vals ? 32'hDEADBEEF : $urandom;
        end
        reset   = ~in_reset;
        if_req  = f_pend && !in_reset;
        if_addr = f_addr;
        d_req   = d_pend && !in_reset;
        d_we    = d_we_r;
        d_be    = d_be_r;
        d_addr  = d_addr_r;
        d_wdata = d_wdata_r;
        mem_ready = roll(p_ready);
        if (m_cd == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = plan_vals ? 32'h00500093 : $urandom;
        end else if (m_cd < 0 && !m_busy && !in_reset && roll(p_spur)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        #1;
        {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_mreq, e_mwe, e_forced} = '0;
        e_mbe = '0; e_maddr = '0; e_mwdata = '0; e_if_rd = '0; e_d_rd = '0;
        if (!in_reset) begin
            if (!m_busy) begin
                // Fetch goes first when data is absent or fetch has already lost LIMIT times.
                if (if_req && (!d_req || m_starve == LIMIT)) begin
                    e_mreq = 1; e_maddr = if_addr;
                    e_if_gnt = mem_ready;
                    e_forced = mem_ready && d_req;
                end else if (d_req) begin
                    e_mreq = 1; e_mwe = d_we; e_mbe = d_be; e_maddr = d_addr; e_mwdata = d_wdata;
                    e_d_gnt = mem_ready;
                end
            end else if (mem_rvalid) begin
                if (m_own_d) begin
                    e_d_rv = 1; e_d_rd = m_own_store ? 32'h0 : mem_rdata;
                end else begin
                    e_if_rv = 1; e_if_rd = mem_rdata;
                end
            end
        end
        obs_d_gnt = d_gnt;
        chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
        chk("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
        chk("if_rvalid", 64'(if_rvalid), 64'(e_if_rv));
        chk("d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
        chk("mem_req", 64'(mem_req), 64'(e_mreq));
        if (e_if_rv || in_reset) chk("if_rdata", 64'(if_rdata), 64'(e_if_rd));
        if (e_d_rv || in_reset)  chk("d_rdata", 64'(d_rdata), 64'(e_d_rd));
        if (!m_busy || in_reset) begin
            chk("mem_addr", 64'(mem_addr), 64'(e_maddr));
            chk("mem_we", 64'(mem_we), 64'(e_mwe));
            chk("mem_be", 64'(mem_be), 64'(e_mbe));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_mwdata));
        end
        chk("stall_if", 64'(stall_if), 64'(if_req && !e_if_rv));
        chk("stall_mem", 64'(stall_mem), 64'(d_req && !e_d_rv));
`ifdef MEM_ARB_PERF_EN
        if (!in_reset) begin
            chk("perf_conflict", 64'(perf_conflict_cnt), 64'(m_pc));
            chk("perf_starve", 64'(perf_starve_cnt), 64'(m_ps));
        end
`endif
        @(posedge clk);
        if (m_cd == 0) m_cd = -1;
        else if (m_cd > 0) m_cd--;
        if (in_reset) begin
            m_busy = 0; m_starve = 0; m_pc = '0; m_ps = '0;
            f_pend = 0; d_pend = 0;
        end else begin
            if (!m_busy && if_req && d_req) m_pc++;
            if (e_forced) m_ps++;
            if (!if_req || e_if_gnt) m_starve = 0;
            else if (e_d_gnt) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
            if (e_if_gnt || e_d_gnt) begin
                m_busy      = 1;
                m_own_d     = e_d_gnt;
                m_own_store = e_d_gnt && d_we;
                m_cd        = int'($urandom_range(lat_hi, lat_lo)) - 1;
            end
            if (e_if_rv) f_pend = 0;
            if (e_d_rv)  d_pend = 0;
            if (e_if_rv || e_d_rv) m_busy = 0;
        end
    endtask

    initial begin
        int guard;
        reset = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0; mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset state: all outputs held at 0.
        in_reset = 1;
        repeat (3) cycle();
        in_reset = 0;

        // Fetch alone at 0x100, memory latency 2.
        plan_vals = 1; p_if = 100; p_d = 0; p_ready = 100; lat_lo = 2; lat_hi = 2;
        repeat (10) cycle();
        // Store with partial byte enables; the ack carries zero data.
        p_if = 0; p_d = 100; lat_lo = 1; lat_hi = 3;
        repeat (12) cycle();
        plan_vals = 0;

        // Memory backpressure on fetch.
        p_if = 100; p_d = 0; p_ready = 25; lat_lo = 1; lat_hi = 2;
        repeat (40) cycle();

        // Conflict and starvation: both requesters always active, back-to-back.
        p_if = 100; p_d = 100; p_ready = 100; lat_lo = 1; lat_hi = 1;
        repeat (60) cycle();

        // Reset one cycle after a data grant, then a stale response arrives while IDLE.
        p_if = 0; p_d = 100; lat_lo = 4; lat_hi = 4;
        repeat (8) cycle();
        guard = 0;
        obs_d_gnt = 0;
        while (!obs_d_gnt && guard < 20) begin
            cycle();
            guard++;
        end
        chk("reset_setup_d_gnt", 64'(obs_d_gnt), 64'(1));
        p_d = 0;
        in_reset = 1;
        cycle();
        in_reset = 0;
        repeat (5) cycle();
        p_if = 100; lat_lo = 1; lat_hi = 3;
        repeat (8) cycle();

        // Random mix with spurious responses.
        p_if = 60; p_d = 60; p_ready = 70; p_spur = 10; lat_lo = 1; lat_hi = 4;
        repeat (1500) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port memory arbiter for the 5-stage core.
- Shares one unified instruction/data memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- One transaction in flight at a time; variable memory latency.
- Generates stall requests back to the pipeline control (fetch write-enable and memory-stage hold).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, number of consecutive data grants made while fetch is waiting before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- if_req  in  1  fetch read request; held until if_rvalid.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted by memory this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  instruction word.
- d_req  in  1  data request; held until d_rvalid.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged.
- d_rdata  out  DATA_W  load data (0 on store ack).
- mem_req  out  1  request to memory.
- mem_we, mem_be, mem_addr, mem_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  forwarded from the granted requester.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  memory response/ack pulse.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  = if_req & ~if_rvalid.
- stall_mem  out  1  = d_req & ~d_rvalid.

Behaviour:
- FSM states: IDLE and WAIT. Owner register: NONE, IF, or D.
- IDLE:
  - Select a requester. D wins, except when starve_cnt == STARVE_LIMIT and if_req = 1, in which case IF wins.
  - mem_req and mem_* are driven combinationally from the selected requester.
  - If mem_ready = 1, pulse the matching *_gnt, latch the owner, and go to WAIT.
  - If mem_ready = 0, stay in IDLE; no gnt.
  - With no requests, mem_req = 0 and mem_* = 0.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid = 1: route mem_rdata to the owner's rdata and pulse the owner's rvalid for one cycle. For a store, d_rdata = 0. Return to IDLE.
  - Earliest next grant is the following cycle, so back-to-back grants are 2 cycles apart.
- Latency: from grant to rvalid equals the memory latency; rvalid is asserted in the same cycle as mem_rvalid (combinational route).
- Starvation counter starve_cnt (4 bits):
  - Increments on each D grant while if_req = 1.
  - Clears on an IF grant, or when if_req = 0.
  - Saturates at STARVE_LIMIT.
- If_req and d_req both 1 in the same cycle: the arbitration rule above applies, and the loser's stall stays high.
- mem_rvalid while in IDLE (spurious, or stale after reset): ignored, no rvalid pulse.
- Reset (reset = 0 at a clk edge):
  - State goes to IDLE, owner to NONE, starve_cnt to 0.
  - All registered outputs go to 0; gnt, rvalid and rdata are 0.
  - Reset may arrive mid-transaction; the outstanding response is then dropped.
- Requester contract: requests are not withdrawn before rvalid. Behaviour under withdrawal is undefined and not verified.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_conflict_cnt [31:0] and perf_starve_cnt [31:0].
  - perf_conflict_cnt increments in each IDLE cycle where if_req & d_req.
  - perf_starve_cnt increments on each forced IF grant.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Fetch alone: if_req = 1, if_addr = 0x100; memory returns 0x00500093 two cycles after grant. Expect if_gnt at cycle 0, if_rvalid with if_rdata = 0x00500093 at cycle 2, stall_if = 1 in cycles 0–1 and 0 at cycle 2.
2. Conflict: if_req and d_req (load from 0x200) asserted together, mem_ready = 1. Expect d_gnt first and stall_if held. After d_rvalid, if_gnt follows one cycle later.
3. Starvation, STARVE_LIMIT = 4: d_req held continuously with back-to-back loads, if_req = 1 throughout. Expect 4 D grants, then an IF grant on the 5th, then starve_cnt = 0.
4. Store: d_we = 1, d_be = 4'b0011, d_addr = 0x40, d_wdata = 0xDEADBEEF. Expect mem_be = 4'b0011 and mem_wdata = 0xDEADBEEF at grant; on ack, d_rvalid = 1 with d_rdata = 0.
5. Memory backpressure: mem_ready = 0 for 3 cycles with if_req = 1. Expect no if_gnt and mem_addr = if_addr throughout; grant on the first cycle mem_ready = 1.
6. Reset mid-WAIT: assert reset = 0 one cycle after d_gnt, release, then the memory delivers mem_rvalid. Expect no d_rvalid, FSM in IDLE, and a new if_req granted normally; with MEM_ARB_PERF_EN, both counters read 0 after reset.
